// File: rtl/avalon_mem_pkg.sv
// Shared types, widths and byte-lane merge helper for the Avalon wait-state RAM.
package avalon_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

  // Replace only the byte lanes selected by be.
  function automatic logic [WORD_W-1:0] be_merge(
    input logic [WORD_W-1:0] old_w,
    input logic [WORD_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [WORD_W-1:0] merged;
    merged = old_w;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_w[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/avalon_wait_ram_if.sv
// Avalon-MM bus between a CPU master and the wait-state RAM responder.
interface avalon_wait_ram_if;
  import avalon_mem_pkg::*;

  logic [31:0]       address;
  logic              write;
  logic              read;
  logic              waitrequest;
  logic [WORD_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic [WORD_W-1:0] readdata;

  modport master (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata
  );

endinterface

// File: rtl/avalon_mem_array.sv
// Word storage: preload port beats bus port on the same word; synchronous read register.
module avalon_mem_array
  import avalon_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pre_we_i,
  input  logic [ADDR_W-1:0] pre_addr_i,
  input  logic [WORD_W-1:0] pre_data_i,
  input  logic              bus_we_i,
  input  logic [ADDR_W-1:0] bus_addr_i,
  input  logic [WORD_W-1:0] bus_data_i,
  input  logic [BE_W-1:0]   bus_be_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WORD_W-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rd_data_q;
  logic              bus_drop;

  assign bus_drop  = pre_we_i && (pre_addr_i == bus_addr_i);
  assign rd_data_o = rd_data_q;

  // Contents survive reset; preload stays live during reset.
  always_ff @(posedge clk) begin
    if (bus_we_i && !bus_drop) begin
      mem_q[bus_addr_i] <= be_merge(mem_q[bus_addr_i], bus_data_i, bus_be_i);
    end
    if (pre_we_i) begin
      mem_q[pre_addr_i] <= pre_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave RAM with programmable wait states, byte-lane writes and a sticky
// master-protocol checker; side-band port preloads the instruction image.
module avalon_wait_ram
  import avalon_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  avalon_wait_ram_if.slave    bus,
  input  logic                inst_input,
  input  logic [7:0]          inst_addr,
  input  logic [WORD_W-1:0]   instruction,
  output logic                protocol_err
);

  localparam int unsigned          CNT_W    = 4;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                wr_q, wr_d;
  logic                perr_q, perr_d;

  logic                req;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic                bus_we;
  logic [1:0]          unused_inst_lsb;

  assign req             = bus.read | bus.write;
  assign bus.waitrequest = req && (state_q != ACK);
  assign bus_we          = (state_q == ACK) && wr_q && !reset;
  assign protocol_err    = perr_q;
  assign unused_inst_lsb = inst_addr[1:0];

  // Next-state, request latches and protocol checker.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    perr_d  = perr_q;
    rd_en   = 1'b0;
    rd_addr = addr_q[ADDR_W+1:2];

    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = bus.address;
          wdata_d = bus.writedata;
          be_d    = bus.byteenable;
          wr_d    = bus.write;
          cnt_d   = '0;
          if (bus.read && bus.write)       perr_d = 1'b1;
          if (bus.address[1:0] != 2'b00)   perr_d = 1'b1;
          if (WAIT_CYCLES != 0) begin
            state_d = BUSY;
          end else begin
            // No wait states: readdata must be captured on the accepting edge.
            state_d = ACK;
            rd_en   = !bus.write;
            rd_addr = bus.address[ADDR_W+1:2];
          end
        end
      end
      BUSY: begin
        if (!req) begin
          state_d = IDLE;
          perr_d  = 1'b1;
        end else begin
          if ((bus.address != addr_q) || (bus.writedata != wdata_q) ||
              (bus.byteenable != be_q)) begin
            perr_d = 1'b1;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ACK;
            rd_en   = !wr_q;
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      perr_q  <= perr_d;
    end
  end

  avalon_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .pre_we_i   (inst_input),
    .pre_addr_i (ADDR_W'(inst_addr[7:2])),
    .pre_data_i (instruction),
    .bus_we_i   (bus_we),
    .bus_addr_i (addr_q[ADDR_W+1:2]),
    .bus_data_i (wdata_q),
    .bus_be_i   (be_q),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (bus.readdata)
  );

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Scoreboard bench: two instances (2 and 0 wait states) driven by directed transfers.
module tb_avalon_wait_ram;

  typedef struct packed {
    logic        chk_rd;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        pin2, pin0;
  logic [7:0]  paddr2, paddr0;
  logic [31:0] pdata2, pdata0;
  logic        perr2, perr0;

  int checks = 0;
  int errors = 0;

  exp_t q2[$];
  exp_t q0[$];

  avalon_wait_ram_if bus2();
  avalon_wait_ram_if bus0();

  avalon_wait_ram #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus2),
    .inst_input   (pin2),
    .inst_addr    (paddr2),
    .instruction  (pdata2),
    .protocol_err (perr2)
  );

  avalon_wait_ram #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus0),
    .inst_input   (pin0),
    .inst_addr    (paddr0),
    .instruction  (pdata0),
    .protocol_err (perr0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ACK must match the oldest expected transfer.
  always @(negedge clk) begin
    exp_t e;
    if ((bus2.read || bus2.write) && !bus2.waitrequest) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL ack2_unexpected: got ACK expected none, rd=%h", bus2.readdata);
      end else begin
        e = q2.pop_front();
        if (e.chk_rd) chk("readdata2", bus2.readdata, e.data);
      end
    end
    if ((bus0.read || bus0.write) && !bus0.waitrequest) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL ack0_unexpected: got ACK expected none, rd=%h", bus0.readdata);
      end else begin
        e = q0.pop_front();
        if (e.chk_rd) chk("readdata0", bus0.readdata, e.data);
      end
    end
  end

  task automatic drive(input bit d0, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    if (d0) begin
      bus0.read = rd; bus0.write = wr; bus0.address = a;
      bus0.writedata = wd; bus0.byteenable = be;
    end else begin
      bus2.read = rd; bus2.write = wr; bus2.address = a;
      bus2.writedata = wd; bus2.byteenable = be;
    end
  endtask

  function automatic bit cur_wait(input bit d0);
    return d0 ? bus0.waitrequest : bus2.waitrequest;
  endfunction

  // One transfer; counts waitrequest cycles, optionally corrupts address in BUSY
  // or fires a preload on the ACK-ending edge.
  task automatic xfer(input string name, input bit d0, input bit rd, input bit wr,
                      input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                      input logic [31:0] exp_rd, input int exp_w, input bit chg,
                      input bit pre_en, input logic [7:0] pa, input logic [31:0] pd);
    exp_t e;
    int   w;
    bit   acked;
    e.chk_rd = rd && !wr;
    e.data   = exp_rd;
    if (d0) q0.push_back(e); else q2.push_back(e);
    drive(d0, rd, wr, a, wd, be);
    w = 0;
    acked = 0;
    for (int i = 0; i < 40 && !acked; i++) begin
      @(negedge clk);
      if (cur_wait(d0)) begin
        w++;
      end else begin
        acked = 1;
        if (pre_en) begin pin2 = 1'b1; paddr2 = pa; pdata2 = pd; end
      end
      @(posedge clk); #1;
      if (!acked && chg && w == 1) begin
        if (d0) bus0.address = a ^ 32'h8; else bus2.address = a ^ 32'h8;
      end
    end
    pin2 = 1'b0;
    drive(d0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checks++;
    if (!acked || w != exp_w) begin
      errors++;
      $display("FAIL %s_waits: got %0d (acked=%0b) expected %0d", name, w, acked, exp_w);
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pin2 = 1'b0; paddr2 = '0; pdata2 = '0;
    pin0 = 1'b0; paddr0 = '0; pdata0 = '0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Preloads issued while reset is held.
    @(posedge clk); #1;
    pin2 = 1'b1; paddr2 = 8'h04; pdata2 = 32'h24020069;
    @(posedge clk); #1;
    paddr2 = 8'h30; pdata2 = 32'h11223344;
    @(posedge clk); #1;
    paddr2 = 8'h0C; pdata2 = 32'h01020304;
    @(posedge clk); #1;
    pin2 = 1'b0;
    @(negedge clk);
    chk("rst_readdata", bus2.readdata, 32'h0);
    chk("rst_perr", 32'(perr2), 32'h0);
    chk("rst_wait_noreq", 32'(bus2.waitrequest), 32'h0);
    bus2.read = 1'b1; bus2.address = 32'h4;
    #1;
    chk("rst_wait_req", 32'(bus2.waitrequest), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Wait states on a read.
    xfer("rd_w1", 0, 1, 0, 32'h4, 32'h0, 4'hF, 32'h24020069, 3, 0, 0, 8'h0, 32'h0);
    @(negedge clk);
    chk("readdata_hold", bus2.readdata, 32'h24020069);
    @(posedge clk); #1;

    // Byte-lane writes, including an all-lanes-off write.
    xfer("wr_be1", 0, 0, 1, 32'h30, 32'h000000AA, 4'b0001, 32'h0, 3, 0, 0, 8'h0, 32'h0);
    xfer("rd_be1", 0, 1, 0, 32'h30, 32'h0, 4'hF, 32'h112233AA, 3, 0, 0, 8'h0, 32'h0);
    xfer("wr_be0", 0, 0, 1, 32'h30, 32'hFFFFFFFF, 4'b0000, 32'h0, 3, 0, 0, 8'h0, 32'h0);
    xfer("rd_be0", 0, 1, 0, 32'h30, 32'h0, 4'hF, 32'h112233AA, 3, 0, 0, 8'h0, 32'h0);
    chk("perr_clean", 32'(perr2), 32'h0);

    // Zero wait states, back-to-back write then read.
    xfer("wr_z", 1, 0, 1, 32'h30, 32'h00000069, 4'hF, 32'h0, 1, 0, 0, 8'h0, 32'h0);
    xfer("rd_z", 1, 1, 0, 32'h30, 32'h0, 4'hF, 32'h00000069, 1, 0, 0, 8'h0, 32'h0);
    chk("perr0_clean", 32'(perr0), 32'h0);

    // Preload collision on same word, then on different words.
    xfer("wr_col", 0, 0, 1, 32'h8, 32'h12345678, 4'hF, 32'h0, 3, 0, 1, 8'h08, 32'hCAFEF00D);
    xfer("rd_col", 0, 1, 0, 32'h8, 32'h0, 4'hF, 32'hCAFEF00D, 3, 0, 0, 8'h0, 32'h0);
    xfer("wr_dif", 0, 0, 1, 32'h14, 32'h11111111, 4'hF, 32'h0, 3, 0, 1, 8'h10, 32'h44444444);
    xfer("rd_dif5", 0, 1, 0, 32'h14, 32'h0, 4'hF, 32'h11111111, 3, 0, 0, 8'h0, 32'h0);
    xfer("rd_dif4", 0, 1, 0, 32'h10, 32'h0, 4'hF, 32'h44444444, 3, 0, 0, 8'h0, 32'h0);

    // Reset during BUSY of a write discards it.
    drive(1'b0, 1'b0, 1'b1, 32'hC, 32'hDEADBEEF, 4'hF);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_readdata", bus2.readdata, 32'h0);
    chk("midrst_perr", 32'(perr2), 32'h0);
    @(posedge clk); #1;
    xfer("rd_midrst", 0, 1, 0, 32'hC, 32'h0, 4'hF, 32'h01020304, 3, 0, 0, 8'h0, 32'h0);

    // Address change in BUSY: sticky error, transfer uses latched address.
    xfer("rd_chg", 0, 1, 0, 32'h4, 32'h0, 4'hF, 32'h24020069, 3, 1, 0, 8'h0, 32'h0);
    chk("perr_chg", 32'(perr2), 32'h1);
    xfer("rd_after", 0, 1, 0, 32'h10, 32'h0, 4'hF, 32'h44444444, 3, 0, 0, 8'h0, 32'h0);
    chk("perr_sticky", 32'(perr2), 32'h1);
    reset_pulse();
    chk("perr_cleared", 32'(perr2), 32'h0);

    // Read and write together: write wins, error flagged.
    xfer("wr_both", 0, 1, 1, 32'h18, 32'h55667788, 4'hF, 32'h0, 3, 0, 0, 8'h0, 32'h0);
    chk("perr_both", 32'(perr2), 32'h1);
    xfer("rd_both", 0, 1, 0, 32'h18, 32'h0, 4'hF, 32'h55667788, 3, 0, 0, 8'h0, 32'h0);
    reset_pulse();

    // Misaligned and aliased address maps to word 1.
    xfer("rd_mis", 0, 1, 0, 32'h1005, 32'h0, 4'hF, 32'h24020069, 3, 0, 0, 8'h0, 32'h0);
    chk("perr_mis", 32'(perr2), 32'h1);

    repeat (2) @(posedge clk);
    chk("q2_drain", 32'(q2.size()), 32'h0);
    chk("q0_drain", 32'(q0.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_wait_ram.md
# avalon_wait_ram

Avalon-MM slave memory model for CPU test benches: the responder end of the CPU's memory bus. It adds a configurable number of wait states on every access so the bench exercises the CPU's `waitrequest` stall handling, applies writes per byte lane, and checks that the master honours the protocol. A side-band preload port lets the bench write the instruction image before or after reset.

## Interface
- `ADDR_W`, 10: word-address bits; memory depth 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 2: wait states inserted per transfer, range 0..15.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `address` in 32: byte address; word index = `address[ADDR_W+1:2]`, upper bits ignored (aliasing).
- `write` in 1: write request.
- `read` in 1: read request.
- `waitrequest` out 1: high means the request is not accepted this cycle.
- `writedata` in 32: write data.
- `byteenable` in 4: bit i enables byte lane `[8i+7:8i]`.
- `readdata` out 32: read data, valid in the ACK cycle.
- `inst_input` in 1: preload strobe.
- `inst_addr` in 8: preload byte address; word index = `inst_addr[7:2]`, zero-extended.
- `instruction` in 32: preload word.
- `protocol_err` out 1: sticky master-violation flag.

## Operation
- FSM states: IDLE, BUSY, ACK.
- **IDLE**
  - If `write` or `read` is high: latch `address`, `writedata`, `byteenable` and the request kind.
  - `write` has priority if both are high; both high also sets `protocol_err`.
  - Next state is BUSY with `cnt`=0 if `WAIT_CYCLES`>0, otherwise ACK.
- **BUSY**
  - `cnt` increments each cycle.
  - When `cnt`==`WAIT_CYCLES`-1, go to ACK.
  - If the request drops, go to IDLE with no commit and set `protocol_err`.
- **ACK**
  - Write: the enabled byte lanes of the latched word are committed at the ACK-ending edge.
  - Read: `readdata` was registered from memory at the edge entering ACK.
  - Always returns to IDLE.
- `waitrequest` = (`read`|`write`) && state!=ACK. It is combinational from the request inputs, so it rises in the same cycle a request is first presented.
- Protocol checks:
  - `protocol_err` sets on any change of `address`, `writedata` or `byteenable` versus the latched value while in BUSY.
  - `protocol_err` sets on `address[1:0]`!=0 at acceptance; the low bits are ignored for the access itself.
- `byteenable`=0000 on a write: the transfer is acknowledged and memory is unchanged.
- `readdata` holds its value outside ACK.
- Preload
  - On any edge with `inst_input`=1, the memory word `inst_addr[7:2]` takes `instruction`, including during `reset`.
  - If the preload and a bus write commit hit the same word on the same edge, the preload wins and the bus write is dropped. Different words are both written.
- Memory contents are never cleared by `reset` and are X after power-up.

## Timing
- Reset values: state IDLE, `cnt` 0, `readdata` 0, `protocol_err` 0. `waitrequest` follows its equation, so it is 1 whenever a request is present during reset.
- Request first presented in cycle k (state IDLE): ACK occurs in cycle k+1+`WAIT_CYCLES`, with `waitrequest`=0 in that cycle.
- Transfer cost is `WAIT_CYCLES`+2 cycles, including one mandatory IDLE cycle.
- Back-to-back requests: the next request is accepted in the IDLE cycle after ACK, and `waitrequest` is high again in that cycle.
- Reset mid-transfer: the FSM returns to IDLE and a pending write is discarded.

## Structure
- Package `avalon_mem_pkg` contains:
  - the `state_t` enum {IDLE, BUSY, ACK};
  - `WORD_W`=32 and `BE_W`=4;
  - a function `be_merge(old, new, be)` returning the byte-lane merge.
- Sub-module `avalon_mem_array`: word storage with two write ports (preload, then bus, in priority order) and one synchronous read port.
- FSM, counter, latches and checker live in the top module.

## Test plan
- **Wait states:** preload word 1 = 0x24020069, `WAIT_CYCLES`=2, read address 0x4 -> `waitrequest` high for 3 cycles, then ACK with `readdata`=0x24020069.
- **Byte-lane write:** word 0x32>>2 preloaded with 0x11223344; write 0x000000AA at address 0x30 with `byteenable`=0001, then read back -> 0x112233AA.
- **Zero wait states and back-to-back:** `WAIT_CYCLES`=0, write 0x69 at address 0x30, then read address 0x30 immediately -> write ACK at k+1, read accepted at k+2, ACK at k+3 with `readdata`=0x69.
- **Protocol violation:** `address` changes mid-BUSY -> `protocol_err`=1 and stays 1 until `reset`. Separately, `read` and `write` both high -> a write occurs and `protocol_err`=1.
- **Reset mid-transfer:** assert `reset` during BUSY of a write of 0xDEADBEEF to word 3 -> word 3 unchanged, FSM in IDLE, `readdata`=0.
- **Preload collision:** preload 0xCAFEF00D to word 2 on the same edge as a bus write of 0x12345678 to word 2 -> read returns 0xCAFEF00D.
